// File: rtl/aes128_serial_core.sv
`timescale 1ns/1ps
// aes128_serial_core: AES-128 block cipher built around one shared byte-wide S-box, one block per start pulse.
// Define AES_DECRYPT_EN to add the inverse cipher and honour enc_dec; without it the core only encrypts.
module aes128_serial_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         enc_dec,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out,
  output logic         ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_KEY, S_SUB, S_MIX, S_KFWD, S_DINIT, S_IKEY, S_ISUB, S_IMIX
  } fsm_e;

  fsm_e         fsm_q;
  logic [127:0] state_q, key_q, data_out_q;
  logic [23:0]  sw_q;
  logic [3:0]   round_q, byte_q;
  logic         ready_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, exactly what the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, base;
    r    = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  // Each output row uses the same four coefficients, rotated one position per row
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  coef;
    logic [7:0]   a [4];
    logic [7:0]   acc;
    o    = '0;
    coef = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(a[k], coef[31-8*((k-r+4)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [31:0] t);
    return {k[127:96] ^ t, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], k[31:0] ^ k[63:32]};
  endfunction

  logic [127:0] isr, imix_out, key_inv;
`else
  logic unused_enc_dec;
  assign unused_enc_dec = enc_dec;
`endif

  logic [1:0]   kbyte;
  logic [31:0]  w3, sub_word, rcon_word;
  logic [3:0]   rcon_idx;
  logic [7:0]   sbox_in, sbox_out;
  logic [127:0] key_fwd, sub_state, sr, mix_out;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    kbyte    = byte_q[1:0] + 2'd1;  // RotWord: SubWord byte k reads w3 byte k+1
    w3       = key_q[31:0];
    rcon_idx = round_q;
`ifdef AES_DECRYPT_EN
    if (fsm_q == S_IKEY) begin
      w3       = key_q[31:0] ^ key_q[63:32];
      rcon_idx = 4'd9 - round_q;
    end
`endif
    sbox_in = state_q[{~byte_q, 3'b000} +: 8];
    if (fsm_q == S_KEY || fsm_q == S_KFWD || fsm_q == S_IKEY) sbox_in = w3[{~kbyte, 3'b000} +: 8];
`ifdef AES_DECRYPT_EN
    sbox_out = (fsm_q == S_ISUB) ? inv_sbox(sbox_in) : fwd_sbox(sbox_in);
`else
    sbox_out = fwd_sbox(sbox_in);
`endif
    sub_word  = {sw_q, sbox_out};
    rcon_word = sub_word ^ {rcon(rcon_idx), 24'h000000};
    key_fwd   = key_step_fwd(key_q, rcon_word);
    sub_state = state_q;
    sub_state[{~byte_q, 3'b000} +: 8] = sbox_out;
    sr        = shift_rows(state_q, 1'b0);
    mix_out   = ((round_q == 4'd9) ? sr : mix_columns(sr, 1'b0)) ^ key_q;
`ifdef AES_DECRYPT_EN
    // InvShiftRows only permutes bytes, so it commutes with the in-place inverse S-box pass
    isr      = shift_rows(state_q, 1'b1) ^ key_q;
    imix_out = (round_q == 4'd9) ? isr : mix_columns(isr, 1'b1);
    key_inv  = key_step_inv(key_q, rcon_word);
`endif
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      state_q    <= '0;
      key_q      <= '0;
      data_out_q <= '0;
      sw_q       <= '0;
      round_q    <= '0;
      byte_q     <= '0;
      ready_q    <= 1'b1;
    end else begin
      case (fsm_q)
        S_IDLE: if (start) begin
          state_q <= data_in;
          key_q   <= key_in;
          round_q <= '0;
          byte_q  <= '0;
          ready_q <= 1'b0;
`ifdef AES_DECRYPT_EN
          fsm_q   <= enc_dec ? S_INIT : S_KFWD;
`else
          fsm_q   <= S_INIT;
`endif
        end
        S_INIT: begin
          state_q <= state_q ^ key_q;
          fsm_q   <= S_KEY;
        end
        S_KEY: begin
          sw_q   <= {sw_q[15:0], sbox_out};
          byte_q <= byte_q + 4'd1;
          if (byte_q == 4'd3) begin
            key_q  <= key_fwd;
            byte_q <= '0;
            fsm_q  <= S_SUB;
          end
        end
        S_SUB: begin
          state_q <= sub_state;
          byte_q  <= byte_q + 4'd1;
          if (byte_q == 4'd15) fsm_q <= S_MIX;
        end
        S_MIX: begin
          state_q <= mix_out;
          if (round_q == 4'd9) begin
            data_out_q <= mix_out;
            ready_q    <= 1'b1;
            fsm_q      <= S_IDLE;
          end else begin
            round_q <= round_q + 4'd1;
            fsm_q   <= S_KEY;
          end
        end
`ifdef AES_DECRYPT_EN
        S_KFWD: begin
          sw_q   <= {sw_q[15:0], sbox_out};
          byte_q <= byte_q + 4'd1;
          if (byte_q == 4'd3) begin
            key_q  <= key_fwd;
            byte_q <= '0;
            if (round_q == 4'd9) begin
              round_q <= '0;
              fsm_q   <= S_DINIT;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        S_DINIT: begin
          state_q <= state_q ^ key_q;
          fsm_q   <= S_IKEY;
        end
        S_IKEY: begin
          sw_q   <= {sw_q[15:0], sbox_out};
          byte_q <= byte_q + 4'd1;
          if (byte_q == 4'd3) begin
            key_q  <= key_inv;
            byte_q <= '0;
            fsm_q  <= S_ISUB;
          end
        end
        S_ISUB: begin
          state_q <= sub_state;
          byte_q  <= byte_q + 4'd1;
          if (byte_q == 4'd15) fsm_q <= S_IMIX;
        end
        S_IMIX: begin
          state_q <= imix_out;
          if (round_q == 4'd9) begin
            data_out_q <= imix_out;
            ready_q    <= 1'b1;
            fsm_q      <= S_IDLE;
          end else begin
            round_q <= round_q + 4'd1;
            fsm_q   <= S_IKEY;
          end
        end
`endif
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_aes128_serial_core.sv
`timescale 1ns/1ps
// Bench for aes128_serial_core: known-answer vectors, busy/abort/back-to-back cases and random blocks
// compared with a table-driven FIPS-197 model.
module tb_aes128_serial_core;

  logic         clk = 1'b0;
  logic         rst, start, enc_dec, ready;
  logic [127:0] data_in, key_in, data_out;
  logic [127:0] prev_exp;
  int           checks = 0;
  int           failures = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];
  typedef logic [10:0][127:0] rk_t;

`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_serial_core dut (
    .clk(clk), .rst(rst), .start(start), .enc_dec(enc_dec),
    .data_in(data_in), .key_in(key_in), .data_out(data_out), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Walks p through all non-zero field elements (times 3) while q tracks its inverse (divide by 3)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    repeat (255) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic rk_t expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rk_t         rk;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    rk_t          rk;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    rk  = expand_key(key);
    blk = pt ^ rk[0];
    for (int round = 1; round <= 10; round++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[blk[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      if (round != 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk = blk ^ rk[round];
    end
    return blk;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
    rk_t          rk;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    rk  = expand_key(key);
    blk = ct ^ rk[10];
    for (int round = 9; round >= 0; round--) begin
      for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = isbox_t[s[r+4*((c-r+4)%4)]];
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      blk = blk ^ rk[round];
      if (round != 0) begin
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gmul(s[4*c], 14) ^ gmul(s[4*c+1], 11) ^ gmul(s[4*c+2], 13) ^ gmul(s[4*c+3], 9);
          t[4*c+1] = gmul(s[4*c], 9)  ^ gmul(s[4*c+1], 14) ^ gmul(s[4*c+2], 11) ^ gmul(s[4*c+3], 13);
          t[4*c+2] = gmul(s[4*c], 13) ^ gmul(s[4*c+1], 9)  ^ gmul(s[4*c+2], 14) ^ gmul(s[4*c+3], 11);
          t[4*c+3] = gmul(s[4*c], 11) ^ gmul(s[4*c+1], 13) ^ gmul(s[4*c+2], 9)  ^ gmul(s[4*c+3], 14);
        end
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      end
    end
    return blk;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a falling edge; the request is captured on the next rising edge.
  task automatic launch(input logic enc, input logic [127:0] k, input logic [127:0] d);
    start = 1'b1; enc_dec = enc; key_in = k; data_in = d;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 128'(ready), 128'd0);
    check("hold_previous_result", data_out, prev_exp);
  endtask

  // Scrambles inputs while busy and optionally re-pulses start at cycle poke_at.
  task automatic wait_done(input string tag, input logic [127:0] exp, input int exp_lat, input int poke_at);
    int lat;
    lat = 1;
    while (!ready && lat < 600) begin
      data_in = rand128();
      key_in  = rand128();
      enc_dec = 1'($urandom_range(0, 1));
      start   = (lat == poke_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 128'(lat - 1), 128'(exp_lat));
    check({tag, "_data"}, data_out, exp);
    prev_exp = exp;
  endtask

  initial begin
    logic [127:0] k, d, exp;
    logic         enc;
    rst = 1'b1; start = 1'b0; enc_dec = 1'b1; data_in = '0; key_in = '0; prev_exp = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_ready", 128'(ready), 128'd1);
    check("reset_data", data_out, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(1'b1, KEY1, PT1);
    wait_done("kat_fips", CT1, 211, 0);
    launch(1'b1, KEY2, PT2);
    wait_done("kat_back_to_back", CT2, 211, 0);
    launch(1'b1, 128'd0, 128'd0);
    wait_done("kat_zero", CT0, 211, 0);
`ifdef AES_DECRYPT_EN
    launch(1'b0, KEY1, CT1);
    wait_done("kat_decrypt", PT1, 251, 0);
`endif
    launch(1'b1, KEY1, PT1);
    wait_done("busy_restart", CT1, 211, 50);

    launch(1'b1, KEY2, PT2);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", 128'(ready), 128'd1);
    check("abort_data", data_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_exp = '0;
    launch(1'b1, KEY2, PT2);
    wait_done("after_abort", CT2, 211, 0);

    for (int i = 0; i < 8; i++) begin
      k   = rand128();
      d   = rand128();
      enc = 1'($urandom_range(0, 1));
      exp = (enc || !DEC_EN) ? aes_enc(k, d) : aes_dec(k, d);
      launch(enc, k, d);
      wait_done("random", exp, (enc || !DEC_EN) ? 211 : 251, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
